// File: rtl/prog_fetch_pkg.sv
// Shared constants, widths and sequencer state type for the writable program store.
package prog_fetch_pkg;

  localparam int unsigned DefInstrW   = 8;
  localparam int unsigned DefAddrW    = 8;
  localparam int unsigned DefNumProgs = 4;

  localparam logic [3:0] OpAdd  = 4'd0;
  localparam logic [3:0] OpSub  = 4'd1;
  localparam logic [3:0] OpMul  = 4'd2;
  localparam logic [3:0] OpDiv  = 4'd3;
  localparam logic [3:0] OpShl  = 4'd4;
  localparam logic [3:0] OpShr  = 4'd5;
  localparam logic [3:0] OpSqa  = 4'd6;
  localparam logic [3:0] OpSqb  = 4'd7;
  localparam logic [3:0] OpPush = 4'd8;
  localparam logic [3:0] OpLda  = 4'd9;
  localparam logic [3:0] OpLdb  = 4'd10;
  localparam logic [3:0] OpOut  = 4'd11;
  localparam logic [3:0] OpBshl = 4'd12;
  localparam logic [3:0] OpBshr = 4'd13;

  localparam logic [1:0] RegR1 = 2'd0;
  localparam logic [1:0] RegR2 = 2'd1;

  typedef enum logic [1:0] {StIdle, StFetch, StPresent, StDone} fetch_state_e;

  // Bank-select width never drops below one bit, even for a single bank.
  function automatic int unsigned psel_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic logic [7:0] mk_instr(logic [3:0] op, logic [1:0] ra, logic [1:0] rb);
    return {op, ra, rb};
  endfunction

endpackage

// File: rtl/prog_fetch_unit_ram.sv
// Synchronous 1R1W memory with a registered read port; contents are not reset.
module prog_ram #(
  parameter int unsigned DataW = 8,
  parameter int unsigned AddrW = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             we_i,
  input  logic [AddrW-1:0] waddr_i,
  input  logic [DataW-1:0] wdata_i,
  input  logic             re_i,
  input  logic [AddrW-1:0] raddr_i,
  output logic [DataW-1:0] rdata_o
);

  logic [DataW-1:0] mem [2**AddrW];

  always_ff @(posedge clk_i) begin
    if (we_i) mem[waddr_i] <= wdata_i;
  end

  // Output register holds its word between reads, which keeps instr stable during stalls.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)   rdata_o <= '0;
    else if (re_i) rdata_o <= mem[raddr_i];
  end

endmodule

// File: rtl/prog_fetch_unit.sv
// Multi-bank writable instruction store with a valid/ready fetch sequencer and run-time loader.
module prog_fetch_unit
  import prog_fetch_pkg::*;
#(
  parameter int unsigned INSTR_W   = DefInstrW,
  parameter int unsigned ADDR_W    = DefAddrW,
  parameter int unsigned NUM_PROGS = DefNumProgs,
  localparam int unsigned PSEL_W   = psel_width(NUM_PROGS)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PSEL_W-1:0]  prog_sel,
  input  logic               start,
  input  logic               abort,
  output logic [INSTR_W-1:0] instr,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [ADDR_W-1:0]  instr_addr,
  output logic               busy,
  output logic               done,
  input  logic               load_en,
  input  logic               load_clr,
  input  logic [PSEL_W-1:0]  load_prog,
  input  logic [ADDR_W-1:0]  load_addr,
  input  logic [INSTR_W-1:0] load_data,
  output logic               load_ack
);

  fetch_state_e      state_q, state_d;
  logic              req_q, req_d;
  logic [PSEL_W-1:0] bank_q, bank_d;
  logic [ADDR_W-1:0] pc_q, pc_d, rd_pc;
  logic [ADDR_W:0]   len_q [NUM_PROGS];
  logic [ADDR_W:0]   len_cur, pc_inc, load_end;
  logic              rd_en, last, load_ok, wr_en;

  assign len_cur  = len_q[bank_q];
  assign pc_inc   = {1'b0, pc_q} + {{ADDR_W{1'b0}}, 1'b1};
  assign load_end = {1'b0, load_addr} + {{ADDR_W{1'b0}}, 1'b1};
  assign last     = (pc_inc >= len_cur);

  // The running bank is locked against the loader; other banks stay writable.
  assign load_ok = (load_en | load_clr) & ~(busy & (load_prog == bank_q));
  assign wr_en   = load_en & ~load_clr & load_ok;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    bank_d  = bank_q;
    pc_d    = pc_q;
    rd_en   = 1'b0;
    rd_pc   = pc_q;
    unique case (state_q)
      StIdle: begin
        // A start is registered first and resolved against len on the following edge.
        if (abort) begin
          req_d = 1'b0;
        end else if (req_q) begin
          req_d   = 1'b0;
          state_d = (len_cur != '0) ? StFetch : StDone;
        end else if (start) begin
          req_d  = 1'b1;
          bank_d = prog_sel;
          pc_d   = '0;
        end
      end
      StFetch: begin
        if (abort) begin
          state_d = StIdle;
        end else begin
          rd_en   = 1'b1;
          state_d = StPresent;
        end
      end
      StPresent: begin
        if (abort) begin
          state_d = StIdle;
        end else if (instr_ready) begin
          if (last) begin
            state_d = StDone;
          end else begin
            pc_d  = pc_inc[ADDR_W-1:0];
            rd_pc = pc_inc[ADDR_W-1:0];
            rd_en = 1'b1;
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      bank_q  <= '0;
      pc_q    <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      bank_q  <= bank_d;
      pc_q    <= pc_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < NUM_PROGS; p++) len_q[p] <= '0;
      load_ack <= 1'b0;
    end else begin
      load_ack <= load_ok;
      if (load_ok) begin
        if (load_clr)                         len_q[load_prog] <= '0;
        else if (load_end > len_q[load_prog]) len_q[load_prog] <= load_end;
      end
    end
  end

  prog_ram #(
    .DataW(INSTR_W),
    .AddrW(PSEL_W + ADDR_W)
  ) u_ram (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .we_i   (wr_en),
    .waddr_i({load_prog, load_addr}),
    .wdata_i(load_data),
    .re_i   (rd_en),
    .raddr_i({bank_q, rd_pc}),
    .rdata_o(instr)
  );

  assign instr_valid = (state_q == StPresent);
  assign busy        = (state_q != StIdle);
  assign done        = (state_q == StDone);
  assign instr_addr  = pc_q;

endmodule

// File: tb/tb_prog_fetch_unit.sv
// Directed bench for prog_fetch_unit with a stream-queue reference model checked every cycle.
module tb_prog_fetch_unit;
  import prog_fetch_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] prog_sel;
  logic       start, abort;
  logic [7:0] instr;
  logic       instr_valid, instr_ready;
  logic [7:0] instr_addr;
  logic       busy, done;
  logic       load_en, load_clr;
  logic [1:0] load_prog;
  logic [7:0] load_addr, load_data;
  logic       load_ack;

  int n_checks = 0;
  int n_err    = 0;

  prog_fetch_unit dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .prog_sel   (prog_sel),
    .start      (start),
    .abort      (abort),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr_addr (instr_addr),
    .busy       (busy),
    .done       (done),
    .load_en    (load_en),
    .load_clr   (load_clr),
    .load_prog  (load_prog),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_ack   (load_ack)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, got, exp);
    end
  endtask

  // Reference model: bank contents/lengths plus the queue of words the current run still owes.
  logic [7:0] mem_m [4][256];
  int         len_m [4];
  int         q_addr[$];
  logic [7:0] q_data[$];
  int         m_age;
  bit         m_busy, m_done, m_stream, m_ack, m_valid_prev, m_acc;
  logic [1:0] m_bank;
  bit         p_start, p_abort, p_ready, p_len, p_lclr;
  logic [1:0] p_sel, p_lprog;
  logic [7:0] p_laddr, p_ldata;

  task automatic model_reset();
    for (int b = 0; b < 4; b++) len_m[b] = 0;
    q_addr.delete();
    q_data.delete();
    m_age = -1; m_busy = 0; m_done = 0; m_stream = 0; m_ack = 0; m_bank = 0;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      model_reset();
      chk("reset_valid", instr_valid, 0);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_load_ack", load_ack, 0);
      chk("reset_instr_addr", instr_addr, 0);
      chk("reset_instr", instr, 0);
    end else begin
      m_acc = m_valid_prev && p_ready && !p_abort;
      m_ack = 0;
      if ((p_len || p_lclr) && !(m_busy && p_lprog == m_bank)) begin
        m_ack = 1;
        if (p_lclr) len_m[p_lprog] = 0;
        else begin
          mem_m[p_lprog][p_laddr] = p_ldata;
          if (int'(p_laddr) + 1 > len_m[p_lprog]) len_m[p_lprog] = int'(p_laddr) + 1;
        end
      end
      if (m_done) begin
        m_done = 0; m_busy = 0; m_age = -1;
      end else if (p_abort && m_age >= 0) begin
        q_addr.delete(); q_data.delete();
        m_stream = 0; m_busy = 0; m_age = -1;
      end else if (m_age >= 0) begin
        m_age++;
        if (m_age == 1) begin
          m_busy = 1;
          if (q_addr.size() == 0) m_done = 1;
        end else if (m_age == 2) begin
          m_stream = 1;
        end else if (m_acc) begin
          void'(q_addr.pop_front());
          void'(q_data.pop_front());
          if (q_addr.size() == 0) begin
            m_stream = 0; m_done = 1;
          end
        end
      end else if (p_start && !p_abort) begin
        m_age  = 0;
        m_bank = p_sel;
        for (int a = 0; a < len_m[p_sel]; a++) begin
          q_addr.push_back(a);
          q_data.push_back(mem_m[p_sel][a]);
        end
      end
      chk("valid", instr_valid, m_stream);
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("load_ack", load_ack, m_ack);
      if (m_stream && instr_valid && q_addr.size() > 0) begin
        chk("instr", instr, q_data[0]);
        chk("instr_addr", instr_addr, q_addr[0]);
      end
    end
    p_start = start; p_abort = abort; p_ready = instr_ready; p_sel = prog_sel;
    p_len = load_en; p_lclr = load_clr; p_lprog = load_prog;
    p_laddr = load_addr; p_ldata = load_data;
    m_valid_prev = m_stream;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [1:0] b, input logic [7:0] a, input logic [7:0] d,
                            input bit clr, input string name);
    load_en = !clr; load_clr = clr; load_prog = b; load_addr = a; load_data = d;
    tick();
    load_en = 0; load_clr = 0;
    chk(name, load_ack, 1);
  endtask

  // Starts a bank and watches it until busy falls; ready/abort/loader are driven per cycle.
  task automatic run_prog(input logic [1:0] bank, input bit toggle, input int abort_addr,
                          input bit do_loads, output int first_valid, output int first_word,
                          output int nvalid, output int nacc, output int ndone,
                          output int done_idx, output int nbusy, output int acks);
    bit seen_busy, fin;
    first_valid = -1; first_word = -1; nvalid = 0; nacc = 0; ndone = 0;
    done_idx = -1; nbusy = 0; acks = 0; seen_busy = 0; fin = 0;
    prog_sel = bank; start = 1;
    tick();
    start = 0;
    for (int i = 0; i < 80 && !fin; i++) begin
      if (instr_valid) begin
        nvalid++;
        if (first_valid < 0) begin first_valid = i; first_word = int'(instr); end
      end
      if (done) begin ndone++; done_idx = i; end
      if (load_ack) acks++;
      if (busy) begin nbusy++; seen_busy = 1; end
      else if (seen_busy) fin = 1;
      if (!fin) begin
        instr_ready = toggle ? (i % 4 == 0 || i % 4 == 3) : 1'b1;
        abort = (abort_addr >= 0) && instr_valid && (int'(instr_addr) == abort_addr);
        if (instr_valid && instr_ready && !abort) nacc++;
        load_en   = do_loads && (i == 4 || i == 5);
        load_prog = (i == 4) ? 2'd0 : 2'd1;
        load_addr = (i == 4) ? 8'd2 : 8'd0;
        load_data = (i == 4) ? 8'hFF : 8'h90;
        tick();
      end
    end
    abort = 0; instr_ready = 0; load_en = 0;
    chk("run_terminates", fin, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1);
  end

  logic [7:0] prog0 [7];
  int fv, fw, nv, na, nd, di, nb, ak;

  initial begin
    prog0 = '{8'h90, 8'hA4, 8'h21, 8'h80, 8'h50, 8'h80, 8'hB0};
    for (int b = 0; b < 4; b++)
      for (int a = 0; a < 256; a++) mem_m[b][a] = '0;
    rst_n = 0; start = 0; abort = 0; prog_sel = 0; instr_ready = 0;
    load_en = 0; load_clr = 0; load_prog = 0; load_addr = 0; load_data = 0;
    repeat (3) tick();
    @(negedge clk); #2 rst_n = 1;
    tick();

    for (int i = 0; i < 7; i++) write_word(2'd0, 8'(i), prog0[i], 0, "load_ack_bank0");

    // Straight stream, ready held high.
    run_prog(2'd0, 0, -1, 0, fv, fw, nv, na, nd, di, nb, ak);
    chk("t1_first_valid_idx", fv, 2);
    chk("t1_first_word", fw, 8'h90);
    chk("t1_valid_cycles", nv, 7);
    chk("t1_accepts", na, 7);
    chk("t1_done_count", nd, 1);
    chk("t1_done_idx", di, 9);
    chk("t1_busy_cycles", nb, 9);

    // Ready pattern 1,0,0,1 with stalls.
    run_prog(2'd0, 1, -1, 0, fv, fw, nv, na, nd, di, nb, ak);
    chk("t2_accepts", na, 7);
    chk("t2_valid_cycles", nv, 14);
    chk("t2_done_idx", di, 16);
    chk("t2_done_count", nd, 1);

    // Empty bank.
    run_prog(2'd3, 0, -1, 0, fv, fw, nv, na, nd, di, nb, ak);
    chk("t3_no_valid", nv, 0);
    chk("t3_done_idx", di, 1);
    chk("t3_busy_cycles", nb, 1);

    // Loader while bank 0 runs: own bank refused, bank 1 accepted.
    run_prog(2'd0, 0, -1, 1, fv, fw, nv, na, nd, di, nb, ak);
    chk("t4_acks", ak, 1);
    chk("t4_accepts", na, 7);
    run_prog(2'd0, 0, -1, 0, fv, fw, nv, na, nd, di, nb, ak);
    chk("t4_rerun_accepts", na, 7);
    run_prog(2'd1, 0, -1, 0, fv, fw, nv, na, nd, di, nb, ak);
    chk("t4_bank1_word", fw, 8'h90);
    chk("t4_bank1_done_idx", di, 3);

    // Abort at address 3, then restart from 0.
    run_prog(2'd0, 0, 3, 0, fv, fw, nv, na, nd, di, nb, ak);
    chk("t5_accepts", na, 3);
    chk("t5_no_done", nd, 0);
    chk("t5_busy_cycles", nb, 5);
    run_prog(2'd0, 0, -1, 0, fv, fw, nv, na, nd, di, nb, ak);
    chk("t5_restart_first_word", fw, 8'h90);
    chk("t5_restart_accepts", na, 7);

    // Out-of-order writes keep the larger length; clear empties a bank.
    write_word(2'd2, 8'd1, mk_instr(OpSqa, RegR1, RegR2), 0, "load_ack_bank2a");
    write_word(2'd2, 8'd0, mk_instr(OpAdd, RegR2, RegR1), 0, "load_ack_bank2b");
    run_prog(2'd2, 0, -1, 0, fv, fw, nv, na, nd, di, nb, ak);
    chk("t6_bank2_valid", nv, 2);
    chk("t6_bank2_first", fw, 8'h04);
    write_word(2'd1, 8'd0, 8'h00, 1, "load_ack_clr");
    run_prog(2'd1, 0, -1, 0, fv, fw, nv, na, nd, di, nb, ak);
    chk("t6_cleared_no_valid", nv, 0);
    chk("t6_cleared_done", nd, 1);

    // Reset mid-stream.
    prog_sel = 0; start = 1; instr_ready = 1;
    tick();
    start = 0;
    repeat (3) tick();
    chk("t7_streaming_before_reset", instr_valid, 1);
    rst_n = 0;
    #1;
    chk("t7_rst_valid", instr_valid, 0);
    chk("t7_rst_busy", busy, 0);
    chk("t7_rst_addr", instr_addr, 0);
    chk("t7_rst_instr", instr, 0);
    instr_ready = 0;
    @(negedge clk); #2 rst_n = 1;
    tick();
    run_prog(2'd0, 0, -1, 0, fv, fw, nv, na, nd, di, nb, ak);
    chk("t7_after_reset_no_valid", nv, 0);
    chk("t7_after_reset_done", nd, 1);
    chk("t7_after_reset_busy", nb, 1);

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
